// File: rtl/alu_control_md.sv
// ALU control for the EX stage: combinational ALUop/FunctionCode decode plus a
// sequencer that starts, stalls for, aborts and completes multi-cycle
// MULT/MULTU/DIV/DIVU operations on the external mult/div unit.
module alu_control_md #(
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              flush,
    input  logic [2:0]        ALUop,
    input  logic [5:0]        FunctionCode,
    output logic [CTRL_W-1:0] ALUctr,
    output logic              illegal,
    output logic              stall,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              md_abort,
    output logic              md_done
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    // Counter preload: BUSY lasts exactly N cycles, counting N-1 down to 0.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [3:0]       ctr4;
    logic             is_md;

    // Operation decode; valid_in deliberately does not gate ALUctr.
    always_comb begin
        ctr4 = 4'b1111;
        case (ALUop)
            3'b000: ctr4 = 4'b0010;
            3'b001: ctr4 = 4'b0110;
            3'b011: ctr4 = 4'b0011;
            3'b111: ctr4 = 4'b0100;
            3'b101: ctr4 = 4'b0101;
            3'b010: begin
                case (FunctionCode)
                    6'b100000: ctr4 = 4'b0010;
                    6'b100010: ctr4 = 4'b0110;
                    6'b100100: ctr4 = 4'b0000;
                    6'b100101: ctr4 = 4'b0001;
                    6'b101010: ctr4 = 4'b0111;
                    6'b100111: ctr4 = 4'b1100;
                    6'b100110: ctr4 = 4'b1101;
                    6'b000000: ctr4 = 4'b1000;
                    6'b000010: ctr4 = 4'b1001;
                    6'b010000: ctr4 = 4'b1010;
                    6'b010010: ctr4 = 4'b1011;
                    6'b011000,
                    6'b011001,
                    6'b011010,
                    6'b011011: ctr4 = 4'b1110;
                    default:   ctr4 = 4'b1111;
                endcase
            end
            default: ctr4 = 4'b1111;
        endcase
    end

    assign ALUctr  = CTRL_W'(ctr4);
    assign illegal = valid_in & (ctr4 == 4'b1111);
    assign is_md   = valid_in & (ALUop == 3'b010) & (FunctionCode[5:2] == 4'b0110);
    assign md_op   = FunctionCode[1:0];

    // Sequencer state and latency counter; synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and handshake outputs; DONE ignores is_md so the op that
    // just finished cannot retrigger while it is still sitting in EX.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        md_start  = 1'b0;
        md_abort  = 1'b0;
        md_done   = 1'b0;
        case (state)
            IDLE: begin
                // A start during reset would never be tracked, so it is held off.
                if (is_md && !flush && !reset) begin
                    md_start  = 1'b1;
                    stall     = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = FunctionCode[1] ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (flush) begin
                    md_abort  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            DONE: begin
                md_done   = ~flush;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
